// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic-library definitions for the bit-serial subtractor.
// Provides the FSM state type and the legal operand-width bounds.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 64;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Optional ovf signal present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// Single-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of one bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first,
// one bit per clock through one fs_cell. Start/done handshake; results
// held until the next accepted start.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of legal range");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 already-computed low bits; the final bit comes
  // straight from the cell on the completion edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] res_cat;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_d, cell_bout;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fs_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state, datapath shifting and completion capture
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    res_cat  = {cell_d, res_q};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = cell_bout;
        res_d  = res_cat[WIDTH-1:1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          diff_d  = res_cat;
          bout_d  = cell_bout;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = brw_q ^ cell_bout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 instance against a cycle-level
// arithmetic model plus directed literals, WIDTH=3 instance exhaustively.
module tb_serial_subtractor;

  logic clk    = 1'b0;
  logic rst8_n = 1'b0;
  logic rst3_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(3)) bus3 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: {bout, diff} of (a - b - bin) over w bits, plain integer math
  function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bin);
    int r;
    logic [8:0] o;
    r = a - b - bin;
    o[8]   = (r < 0);
    o[7:0] = 8'(r & ((1 << w) - 1));
    return o;
  endfunction

  // Reference: signed 8-bit overflow of a - b - bin
  function automatic logic ref_ovf8(input int a, input int b, input int bin);
    int sa, sb, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r  = sa - sb - bin;
    return (r < -128) || (r > 127);
  endfunction

  // Cycle model for the WIDTH=8 instance
  int         m_left;
  logic       m_done, m_bout, m_ovf, p_bout, p_ovf;
  logic [7:0] m_diff, p_diff;
  logic [8:0] m_tmp;

  always @(posedge clk or negedge rst8_n) begin
    if (!rst8_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
      p_diff <= '0;
      p_bout <= 1'b0;
      p_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_diff <= p_diff;
          m_bout <= p_bout;
          m_ovf  <= p_ovf;
          m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end else if (bus8.start) begin
        m_tmp   = ref_sub(8, int'(bus8.a), int'(bus8.b), int'(bus8.bin));
        p_diff <= m_tmp[7:0];
        p_bout <= m_tmp[8];
        p_ovf  <= ref_ovf8(int'(bus8.a), int'(bus8.b), int'(bus8.bin));
        m_left <= 8;
      end
    end
  end

  // Every-cycle comparison of the WIDTH=8 instance against the model
  always @(negedge clk) begin
`ifdef SERIAL_SUB_OVF_EN
    check("cyc8", {bus8.ovf, bus8.busy, bus8.done, bus8.bout, bus8.diff},
                  {m_ovf, (m_left > 0), m_done, m_bout, m_diff});
`else
    check("cyc8", {bus8.busy, bus8.done, bus8.bout, bus8.diff},
                  {(m_left > 0), m_done, m_bout, m_diff});
`endif
  end

  task automatic wait_done8(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus8.done) check("timeout8", 64'(bus8.done), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output int lat, output int bcnt);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bin;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.bin   = 1'($urandom);
    wait_done8(lat, bcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat, bcnt, lat3;
    logic saw;
    logic [8:0] e3;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.bin = 1'b0;

    // Pin the reference model with hand-computed values
    check("pin_ref8", 64'(ref_sub(8, 'h00, 'h01, 0)), 64'h1FF);
    check("pin_ref3", 64'(ref_sub(3, 2, 5, 1)), 64'h104);
    check("pin_ovf8", 64'(ref_ovf8('h80, 'h01, 0)), 64'd1);

    repeat (2) @(negedge clk);
    check("reset_out8", {bus8.busy, bus8.done, bus8.bout, bus8.diff}, '0);
    rst8_n = 1'b1;
    rst3_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, lat, bcnt);
    check("lat_5a", 64'(lat), 64'd8);
    check("busy_5a", 64'(bcnt), 64'd8);
    check("res_5a", {bus8.bout, bus8.diff}, {1'b0, 8'h1E});

    op8(8'h00, 8'h01, 1'b0, lat, bcnt);
    check("res_00_01", {bus8.bout, bus8.diff}, {1'b1, 8'hFF});

    op8(8'hFF, 8'hFF, 1'b1, lat, bcnt);
    check("res_ff_ff_1", {bus8.bout, bus8.diff}, {1'b1, 8'hFF});

    op8(8'h80, 8'h01, 1'b0, lat, bcnt);
    check("res_80_01", {bus8.bout, bus8.diff}, {1'b0, 8'h7F});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf_80_01", 64'(bus8.ovf), 64'd1);
`endif

    op8(8'h05, 8'h03, 1'b0, lat, bcnt);
    check("res_05_03", {bus8.bout, bus8.diff}, {1'b0, 8'h02});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf_05_03", 64'(bus8.ovf), 64'd0);
`endif

    // Start pulsed again mid-SHIFT with different operands
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h11; bus8.bin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(lat, bcnt);
    check("ignore_lat", 64'(lat), 64'd5);
    check("ignore_res", {bus8.bout, bus8.diff}, {1'b0, 8'h0F});

    // Start held high through DONE: back-to-back operations
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h30; bus8.b = 8'h10; bus8.bin = 1'b0;
    @(negedge clk);
    wait_done8(lat, bcnt);
    check("b2b_res1", {bus8.bout, bus8.diff}, {1'b0, 8'h20});
    bus8.a = 8'h07; bus8.b = 8'h09; bus8.bin = 1'b0;
    @(negedge clk);
    check("b2b_nogap", {bus8.busy, bus8.done}, 2'b10);
    bus8.start = 1'b0;
    wait_done8(lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd8);
    check("b2b_res2", {bus8.bout, bus8.diff}, {1'b1, 8'hFE});

    // Reset in the fourth cycle of an operation
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1 check("rst_mid", {bus8.busy, bus8.done, bus8.bout, bus8.diff}, '0);
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | bus8.done;
    end
    check("rst_no_done", 64'(saw), 64'd0);
    op8(8'h44, 8'h22, 1'b1, lat, bcnt);
    check("post_rst_res", {bus8.bout, bus8.diff}, {1'b0, 8'h21});

    // WIDTH=3 exhaustive sweep
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          bus3.start = 1'b1; bus3.a = 3'(a); bus3.b = 3'(b); bus3.bin = 1'(c);
          @(negedge clk);
          bus3.start = 1'b0;
          lat3 = 0;
          while (!bus3.done && lat3 < 20) begin
            @(negedge clk);
            lat3++;
          end
          e3 = ref_sub(3, a, b, c);
          check("w3", {4'(lat3), bus3.bout, bus3.diff}, {4'd3, e3[8], e3[2:0]});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised bit-serial subtractor: computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock, through a single full-subtractor cell.
Start/done handshake; operands captured on start; result and final borrow held until the next start.
Next-generation sequential, width-generic replacement for the single-bit combinational full subtractor in the arithmetic library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse: result valid
diff  output  WIDTH  difference, registered, held until the next accepted start
bout  output  1  final borrow-out, registered, held with diff

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow and counter cleared.
- State IDLE:
  - start=1 at a rising edge: load a_sh=a, b_sh=b, brw=bin, cnt=0; go to SHIFT.
- State SHIFT, each cycle:
  - d = a_sh[0]^b_sh[0]^brw.
  - brw_next = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
  - a_sh and b_sh shift right; d shifts into res MSB; cnt increments.
  - When cnt==WIDTH-1: go to DONE.
  - On that same edge: diff<=final res, bout<=brw_next, done<=1.
- State DONE, lasts one cycle, done=1:
  - start=1: accept a new operation exactly as from IDLE (back-to-back, no idle gap).
  - Otherwise go to IDLE.
  - done falls after one cycle in either case.
- Latency:
  - Start accepted at edge E0 → done visible after edge E0+WIDTH.
  - busy high for the WIDTH cycles between those edges.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy=1: ignored, no effect on operands or progress.
- diff/bout keep their old values during SHIFT; they update only on the completion edge.
- Arithmetic is unsigned modulo 2^WIDTH:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin, with the comparison done in WIDTH+1 bits.
- Reset asserted mid-operation: abort immediately to the reset state; no done pulse; partial result discarded.
- Operand inputs need not be held stable after the start edge.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output ovf (1 bit, reset 0), registered with diff.
  - ovf = two's-complement signed overflow = brw_in_to_MSB ^ brw_out_of_MSB, captured on the completion edge.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package arith_pkg:
  - FSM state typedef: IDLE, SHIFT, DONE, 2-bit encoding.
  - Constant for the minimum legal WIDTH.
- One sub-module, fs_cell: purely combinational 1-bit cell, (a, b, bin) → (d, bout); instantiated once.
- Top contains the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0 → done after 8 cycles, diff=0x1E, bout=0, busy high exactly 8 cycles.
- WIDTH=8, a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1; then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- Start pulsed again mid-SHIFT with different operands → ignored; original result delivered on schedule. Start held high in DONE → next op begins with no idle cycle.
- Reset dropped at cycle 4 of an operation → all outputs 0 at once, no done pulse; new start afterwards yields a correct result.
- WIDTH=3, exhaustive a, b, bin (128 cases) → diff and bout match the mod-8 arithmetic model for every case.
- SERIAL_SUB_OVF_EN defined, WIDTH=8: a=0x80, b=0x01 → diff=0x7F, ovf=1; a=0x05, b=0x03 → diff=0x02, ovf=0.
